// File: rtl/segment_char_decoder.sv
`default_nettype none
// ============================================================================
// Module   : segment_char_decoder
// Brief    : Debounces a raw 7-segment pattern and decodes it to ASCII,
//            emitting each new stable pattern once on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module segment_char_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Segments,
    output logic [7:0] o_Char,
    output logic       o_Unknown,
    output logic       o_Valid,
    input  logic       i_Ready
);

    localparam logic [1:0] c_SETTLE = 2'd0;
    localparam logic [1:0] c_EMIT   = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;

    localparam logic [8:0] c_STABLE = 9'(STABLE_CYCLES);
    localparam logic [7:0] c_BLANK  = 8'h20;
    localparam logic [7:0] c_QMARK  = 8'h3F;

    logic [1:0] r_state, w_state_next;
    logic [6:0] r_seg_raw;
    logic [6:0] w_pat;
    logic [6:0] r_cand, w_cand_next;
    logic [7:0] r_cnt, w_cnt_next;
    logic [6:0] r_last, w_last_next;
    logic       r_have_last, w_have_last_next;
    logic [7:0] r_char, w_char_next;
    logic       r_unknown, w_unknown_next;
    logic       r_valid, w_valid_next;
    logic [8:0] w_cnt_inc;
    logic       w_stable;
    logic [7:0] w_dec_char;

    function automatic logic [7:0] f_decode(input logic [6:0] p);
        logic [7:0] c;
        case (p)
            7'b1111110: c = 8'h30;
            7'b0110000: c = 8'h31;
            7'b1101101: c = 8'h32;
            7'b1111001: c = 8'h33;
            7'b0110011: c = 8'h34;
            7'b1011011: c = 8'h35;
            7'b1011111: c = 8'h36;
            7'b1110000: c = 8'h37;
            7'b1111111: c = 8'h38;
            7'b1111011: c = 8'h39;
            7'b1110111: c = 8'h41;
            7'b0011111: c = 8'h62;
            7'b1001110: c = 8'h43;
            7'b0111101: c = 8'h64;
            7'b1001111: c = 8'h45;
            7'b1000111: c = 8'h46;
            7'b0110111: c = 8'h48;
            7'b0001110: c = 8'h4C;
            7'b0010101: c = 8'h6E;
            7'b0011101: c = 8'h6F;
            7'b1100111: c = 8'h50;
            7'b0000101: c = 8'h72;
            7'b0001111: c = 8'h74;
            7'b0111110: c = 8'h55;
            7'b0000001: c = 8'h2D;
            7'b0000000: c = 8'h20;
            default:    c = 8'h3F;
        endcase
        return c;
    endfunction

    // Pure input pipeline stage; left out of reset so a pattern held across
    // reset is visible on the first cycle after release.
    always_ff @(posedge i_Clk) begin
        r_seg_raw <= i_Segments;
    end

    assign w_pat      = ACTIVE_LOW ? ~r_seg_raw : r_seg_raw;
    assign w_cnt_inc  = {1'b0, r_cnt} + 9'd1;
    assign w_stable   = (w_cnt_inc >= c_STABLE);
    assign w_dec_char = f_decode(r_cand);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= c_SETTLE;
            r_cand      <= 7'd0;
            r_cnt       <= 8'd0;
            r_last      <= 7'd0;
            r_have_last <= 1'b0;
            r_char      <= c_BLANK;
            r_unknown   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cand      <= w_cand_next;
            r_cnt       <= w_cnt_next;
            r_last      <= w_last_next;
            r_have_last <= w_have_last_next;
            r_char      <= w_char_next;
            r_unknown   <= w_unknown_next;
            r_valid     <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cand_next      = r_cand;
        w_cnt_next       = r_cnt;
        w_last_next      = r_last;
        w_have_last_next = r_have_last;
        w_char_next      = r_char;
        w_unknown_next   = r_unknown;
        w_valid_next     = r_valid;

        case (r_state)
            c_SETTLE: begin
                if (w_pat != r_cand) begin
                    w_cand_next = w_pat;
                    w_cnt_next  = 8'd0;
                end else begin
                    w_cnt_next = w_stable ? c_STABLE[7:0] : w_cnt_inc[7:0];
                    if (w_stable) begin
                        // A pattern that merely returns to the last emitted one is swallowed.
                        if (r_have_last && (r_cand == r_last)) begin
                            w_state_next = c_HOLD;
                        end else begin
                            w_char_next    = w_dec_char;
                            w_unknown_next = (w_dec_char == c_QMARK);
                            w_valid_next   = 1'b1;
                            w_state_next   = c_EMIT;
                        end
                    end
                end
            end
            c_EMIT: begin
                if (i_Ready) begin
                    w_valid_next     = 1'b0;
                    w_last_next      = r_cand;
                    w_have_last_next = 1'b1;
                    w_state_next     = c_HOLD;
                end
            end
            c_HOLD: begin
                if (w_pat != r_last) begin
                    w_cand_next  = w_pat;
                    w_cnt_next   = 8'd0;
                    w_state_next = c_SETTLE;
                end
            end
            default: begin
                w_state_next = c_SETTLE;
            end
        endcase
    end

    assign o_Char    = r_char;
    assign o_Unknown = r_unknown;
    assign o_Valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_segment_char_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_segment_char_decoder
// Brief    : Directed and randomised checks of segment_char_decoder against a
//            table-driven reference of the emitted character stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_char_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_al, seg_ah;
    logic       rdy_al, rdy_ah;
    logic [7:0] ch_al, ch_ah;
    logic       unk_al, unk_ah, vld_al, vld_ah;

    int tests = 0;
    int fails = 0;

    logic [8:0] q_al[$];
    logic [8:0] q_ah[$];
    logic [8:0] exp_q[$];

    logic [6:0] pats [0:25] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
        7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111,
        7'b1000111, 7'b0110111, 7'b0001110, 7'b0010101, 7'b0011101,
        7'b1100111, 7'b0000101, 7'b0001111, 7'b0111110, 7'b0000001,
        7'b0000000};
    string chars = "0123456789AbCdEFHLnoPrtU- ";

    always #5 clk = ~clk;

    segment_char_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_al (
        .i_Clk(clk), .i_Reset(rst), .i_Segments(seg_al), .o_Char(ch_al),
        .o_Unknown(unk_al), .o_Valid(vld_al), .i_Ready(rdy_al));

    segment_char_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_ah (
        .i_Clk(clk), .i_Reset(rst), .i_Segments(seg_ah), .o_Char(ch_ah),
        .o_Unknown(unk_ah), .o_Valid(vld_ah), .i_Ready(rdy_ah));

    // Every accepted character is logged as {unknown, char}.
    always @(negedge clk) begin
        if (vld_al && rdy_al) q_al.push_back({unk_al, ch_al});
        if (vld_ah && rdy_ah) q_ah.push_back({unk_ah, ch_ah});
    end

    function automatic logic [8:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 26; i++)
            if (pats[i] == p) return {1'b0, chars[i]};
        return {1'b1, 8'h3F};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [8:0] q_at(input int which, input int i);
        if (which == 0) return (i < q_al.size()) ? q_al[i] : 9'h1FF;
        return (i < q_ah.size()) ? q_ah[i] : 9'h1FF;
    endfunction

    initial begin
        logic [6:0] p, prev, last;
        logic       has_last, long_run;
        int         len;

        // Reset with blank held; blank must be emitted exactly once.
        rst = 1'b1; seg_al = 7'h7F; seg_ah = 7'h00; rdy_al = 1'b1; rdy_ah = 1'b1;
        tick(2);
        check("rst_valid", 32'(vld_al), 32'd0);
        check("rst_char", 32'(ch_al), 32'h20);
        check("rst_unknown", 32'(unk_al), 32'd0);
        check("rst_valid_ah", 32'(vld_ah), 32'd0);
        rst = 1'b0;
        q_al.delete();
        tick(12);
        check("blank_count", q_al.size(), 32'd1);
        check("blank_char", 32'(q_at(0, 0)), 32'h020);

        // Latency, backpressure hold, then the queued change to '8'.
        q_al.delete();
        seg_al = 7'b0000110; rdy_al = 1'b0;
        tick(5);
        check("lat_early", 32'(vld_al), 32'd0);
        tick(1);
        check("lat_valid", 32'(vld_al), 32'd1);
        check("lat_char", 32'(ch_al), 32'h33);
        seg_al = ~7'b1111111;
        tick(6);
        check("bp_valid", 32'(vld_al), 32'd1);
        check("bp_char", 32'(ch_al), 32'h33);
        rdy_al = 1'b1;
        tick(1);
        check("hs_drop", 32'(vld_al), 32'd0);
        tick(4);
        check("eight_early", 32'(vld_al), 32'd0);
        tick(1);
        check("eight_valid", 32'(vld_al), 32'd1);
        check("eight_char", 32'(ch_al), 32'h38);
        tick(1);
        check("seq_count", q_al.size(), 32'd2);
        check("seq_0", 32'(q_at(0, 0)), 32'h033);
        check("seq_1", 32'(q_at(0, 1)), 32'h038);

        // Short glitch away from and back to the last emitted pattern.
        seg_al = 7'b0000110;
        tick(10);
        q_al.delete();
        seg_al = ~7'b1110000;
        tick(2);
        seg_al = 7'b0000110;
        tick(12);
        check("glitch_none", q_al.size(), 32'd0);

        // Pattern outside the table.
        q_al.delete();
        seg_al = ~7'b1010101;
        tick(10);
        check("unk_count", q_al.size(), 32'd1);
        check("unk_entry", 32'(q_at(0, 0)), 32'h13F);

        // Reset while a character is pending.
        q_al.delete();
        rdy_al = 1'b0; seg_al = ~7'b1011011;
        tick(6);
        check("pend_valid", 32'(vld_al), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rstemit_valid", 32'(vld_al), 32'd0);
        check("rstemit_char", 32'(ch_al), 32'h20);
        check("rstemit_unk", 32'(unk_al), 32'd0);
        rst = 1'b0;
        tick(4);
        check("reemit_early", 32'(vld_al), 32'd0);
        tick(1);
        check("reemit_valid", 32'(vld_al), 32'd1);
        check("reemit_char", 32'(ch_al), 32'h35);
        rdy_al = 1'b1;
        tick(1);

        // Full table sweep on the active-high instance.
        tick(10);
        q_ah.delete();
        for (int i = 0; i < 26; i++) begin
            seg_ah = pats[i];
            tick(8);
        end
        tick(4);
        check("sweep_count", q_ah.size(), 32'd26);
        for (int i = 0; i < 26; i++)
            check($sformatf("sweep_%0d", i), 32'(q_at(1, i)), 32'(ref_decode(pats[i])));

        // Random long/short runs against the emitted-stream reference.
        rst = 1'b1; seg_al = 7'h7F; rdy_al = 1'b1;
        tick(2);
        rst = 1'b0;
        q_al.delete();
        exp_q.delete();
        prev = 7'd0; last = 7'd0; has_last = 1'b0;
        for (int r = 0; r < 40; r++) begin
            do begin
                if ($urandom_range(0, 3) == 0) p = 7'($urandom);
                else p = pats[$urandom_range(0, 25)];
            end while (p == prev);
            long_run = (r == 39) || ($urandom_range(0, 2) != 0);
            len = long_run ? int'($urandom_range(8, 14)) : int'($urandom_range(1, 2));
            seg_al = ~p;
            tick(len);
            if (long_run) begin
                if (!has_last || p != last) exp_q.push_back(ref_decode(p));
                has_last = 1'b1;
                last = p;
            end
            prev = p;
        end
        tick(10);
        check("rand_count", q_al.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_%0d", i), 32'(q_at(0, i)), 32'(exp_q[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
